sseg_display_arbiter: RTL and testbench

Shares the 8-digit seven-segment display between N_CLIENTS requesters. Each client holds the display for at least HOLD_CYCLES, and clients take turns in round-robin order. The block captures the owning client's 32-bit hex value, converts it to eight active-low segment bytes and drives the `data_i[0:7]` array of the display time-slot multiplexer. Clients sit upstream (counters, debug taps, UART status); the display mux sits downstream.

---
 rtl/sseg_pkg.sv | 14 +
 rtl/hex_to_sseg.sv | 16 +
 rtl/sseg_display_arbiter.sv | 148 ++++++++++++++
 tb/tb_sseg_display_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
// Segment bytes are active-low: bit 7 = DP, bits 6:0 = g..a.
package sseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {IDLE, HOLD} arb_state_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex-nibble to active-low segment byte converter with DP and blank.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    if (blank) seg = SEG_BLANK;
    else       seg = {~dp, HEX_SEG[nibble][6:0]};
  end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter sharing the 8-digit seven-segment display between clients;
// snapshots the owner's value, decodes it and registers the segment bytes.
module sseg_display_arbiter
  import sseg_pkg::*;
#(
  parameter int N_CLIENTS   = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_CLIENTS-1:0]          req_i,
  input  logic [N_CLIENTS-1:0][31:0]    value_i,
  input  logic [N_CLIENTS-1:0][7:0]     dp_i,
  input  logic [N_CLIENTS-1:0][7:0]     blank_i,
  output logic [N_CLIENTS-1:0]          grant_o,
  output logic [$clog2(N_CLIENTS)-1:0]  owner_o,
  output logic                          busy_o,
  output logic [7:0][7:0]               data_o
);

  localparam int OW = $clog2(N_CLIENTS);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0]        CNT_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
  localparam logic [OW-1:0]        OWNER_LAST = OW'(N_CLIENTS - 1);
  localparam logic [N_CLIENTS-1:0] ONE_HOT0   = N_CLIENTS'(1);

  arb_state_t      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            expired_q, expired_d;
  logic [31:0]     snap_val_q, snap_val_d;
  logic [7:0]      snap_dp_q, snap_dp_d;
  logic [7:0]      snap_blank_q, snap_blank_d;
  logic [7:0][7:0] data_q;
  logic [7:0][7:0] seg_w;

  logic [N_CLIENTS-1:0] others;
  logic                 load_snap;

  // First requester strictly after prev, wrapping; prev itself is checked last.
  function automatic logic [OW-1:0] rr_pick(input logic [N_CLIENTS-1:0] req,
                                            input logic [OW-1:0]        prev);
    int   idx;
    logic found;
    rr_pick = prev;
    found   = 1'b0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      idx = (int'(prev) + i) % N_CLIENTS;
      if (!found && req[idx]) begin
        rr_pick = OW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    expired_d = expired_q;
    load_snap = 1'b0;
    others    = req_i & ~(ONE_HOT0 << owner_q);

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = HOLD;
          owner_d   = rr_pick(req_i, last_q);
          cnt_d     = '0;
          expired_d = 1'b0;
          load_snap = 1'b1;
        end
      end
      HOLD: begin
        if (!expired_q) begin
          load_snap = req_i[owner_q];
          if (cnt_q != CNT_LAST) begin
            cnt_d     = cnt_q + CNT_ONE;
            expired_d = ((cnt_q + CNT_ONE) == CNT_LAST);
          end else begin
            expired_d = 1'b1;
          end
        end else if (|others) begin
          // Direct handover: the new owner's inputs load at the same edge.
          owner_d   = rr_pick(others, owner_q);
          last_d    = owner_q;
          cnt_d     = '0;
          expired_d = 1'b0;
          load_snap = 1'b1;
        end else if (req_i[owner_q]) begin
          load_snap = 1'b1;
        end else begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    snap_val_d   = load_snap ? value_i[owner_d] : snap_val_q;
    snap_dp_d    = load_snap ? dp_i[owner_d]    : snap_dp_q;
    snap_blank_d = load_snap ? blank_i[owner_d] : snap_blank_q;
  end

  for (genvar d = 0; d < 8; d++) begin : g_digit
    hex_to_sseg u_hex_to_sseg (
      .nibble (snap_val_q[4*d +: 4]),
      .dp     (snap_dp_q[d]),
      .blank  (snap_blank_q[d]),
      .seg    (seg_w[d])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_q       <= OWNER_LAST;
      cnt_q        <= '0;
      expired_q    <= 1'b0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      data_q       <= {8{SEG_BLANK}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      expired_q    <= expired_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      data_q       <= (state_q == HOLD) ? seg_w : {8{SEG_BLANK}};
    end
  end

  assign busy_o  = (state_q == HOLD);
  assign grant_o = busy_o ? (ONE_HOT0 << owner_q) : '0;
  assign owner_o = owner_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Self-checking bench: decode table, directed multi-cycle sequences and a
// randomized run against an ownership/age-based reference model.
module tb_sseg_display_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [63:0] ALL_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0][31:0]  value;
  logic [N-1:0][7:0]   dp;
  logic [N-1:0][7:0]   blank;
  logic [N-1:0]        grant;
  logic [1:0]          owner;
  logic                busy;
  logic [7:0][7:0]     data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sseg_display_arbiter #(.N_CLIENTS(N), .HOLD_CYCLES(HOLD)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .value_i (value),
    .dp_i    (dp),
    .blank_i (blank),
    .grant_o (grant),
    .owner_o (owner),
    .busy_o  (busy),
    .data_o  (data)
  );

  typedef struct {
    int          client;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Expected display contents straight from the digit/DP/blank rules.
  function automatic logic [63:0] display_of(input logic [31:0] v, input logic [7:0] d,
                                             input logic [7:0] b);
    logic [63:0] r;
    logic [7:0]  s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s    = HEX[v[4*i +: 4]];
      s[7] = ~d[i];
      if (b[i]) s = 8'hFF;
      r[8*i +: 8] = s;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req   = '0;
    value = '0;
    dp    = '0;
    blank = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int          m_owner;   // -1 when idle
  int          m_shown;
  int          m_last;
  int          m_age;     // cycles the current grant has been visible
  logic [31:0] m_val;
  logic [7:0]  m_dp, m_blank;
  logic [63:0] m_data;

  function automatic int rr(input logic [N-1:0] r, input int from);
    for (int i = 0; i < N; i++)
      if (r[(from + i) % N]) return (from + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_shown = 0;
    m_last  = N - 1;
    m_age   = 0;
    m_val   = '0;
    m_dp    = '0;
    m_blank = '0;
    m_data  = ALL_BLANK;
  endtask

  task automatic model_step();
    int           nxt;
    logic [N-1:0] oth;
    logic         take;
    m_data = (m_owner >= 0) ? display_of(m_val, m_dp, m_blank) : ALL_BLANK;
    take   = 1'b0;
    nxt    = m_owner;
    if (m_owner < 0) begin
      if (req != '0) begin
        nxt   = rr(req, (m_last + 1) % N);
        m_age = 1;
        take  = 1'b1;
      end
    end else if (m_age < HOLD) begin
      m_age++;
      take = req[m_owner];
    end else begin
      oth = req & ~(4'b0001 << m_owner);
      if (oth != '0) begin
        m_last = m_owner;
        nxt    = rr(oth, (m_owner + 1) % N);
        m_age  = 1;
        take   = 1'b1;
      end else if (req[m_owner]) begin
        take = 1'b1;
      end else begin
        m_last = m_owner;
        nxt    = -1;
      end
    end
    m_owner = nxt;
    if (nxt >= 0) m_shown = nxt;
    if (take) begin
      m_val   = value[nxt];
      m_dp    = dp[nxt];
      m_blank = blank[nxt];
    end
  endtask

  initial begin
    logic [N-1:0] eg;
    logic [63:0]  dy;

    rst = 1'b1;
    clear_inputs();

    // Reset state
    do_reset(3);
    check("reset grant", 64'(grant), 64'(0));
    check("reset busy",  64'(busy),  64'(0));
    check("reset owner", 64'(owner), 64'(0));
    check("reset data",  data,       ALL_BLANK);

    // Decode table, one client at a time from reset
    tbl[0] = '{2, 32'h0000_00A7, 8'h00, 8'h00, 64'hC0C0_C0C0_C0C0_88F8};
    tbl[1] = '{0, 32'h1234_5678, 8'h01, 8'hF0, 64'hFFFF_FFFF_9282_F800};
    tbl[2] = '{3, 32'h89AB_CDEF, 8'h00, 8'h00, 64'h8090_8883_C6A1_868E};
    tbl[3] = '{1, 32'h0123_4567, 8'hFF, 8'h00, 64'h4079_2430_1912_0278};
    tbl[4] = '{2, 32'h0000_0000, 8'h55, 8'hAA, 64'hFF40_FF40_FF40_FF40};
    for (int i = 0; i < 5; i++) begin
      do_reset(2);
      clear_inputs();
      value[tbl[i].client] = tbl[i].value;
      dp[tbl[i].client]    = tbl[i].dp;
      blank[tbl[i].client] = tbl[i].blank;
      req = 4'b0001 << tbl[i].client;
      tick();
      check("tbl grant", 64'(grant), 64'(4'b0001 << tbl[i].client));
      check("tbl owner", 64'(owner), 64'(tbl[i].client));
      check("tbl data early", data, ALL_BLANK);
      tick();
      check("tbl data", data, tbl[i].exp_data);
      clear_inputs();
    end

    // All clients requesting: each owns exactly HOLD cycles, no gap
    do_reset(2);
    clear_inputs();
    req = 4'b1111;
    for (int k = 0; k < 5 * HOLD; k++) begin
      tick();
      eg = 4'b0001 << ((k / HOLD) % N);
      check("rr grant", 64'(grant), 64'(eg));
    end
    clear_inputs();

    // Early drop: display freezes, ownership lasts HOLD cycles, then blanks
    do_reset(2);
    clear_inputs();
    value[1] = 32'hDEAD_BEEF;
    req      = 4'b0010;
    tick();                               // grant edge
    check("drop grant0", 64'(grant), 64'(4'b0010));
    value[1] = 32'h0C0F_FEE5;
    dp[1]    = 8'h81;
    dy       = display_of(32'h0C0F_FEE5, 8'h81, 8'h00);
    tick();                               // last live sample
    check("drop data0", data, display_of(32'hDEAD_BEEF, 8'h00, 8'h00));
    req      = 4'b0000;
    value[1] = 32'h1111_1111;
    for (int k = 2; k < HOLD; k++) begin
      tick();
      check("drop grant", 64'(grant), 64'(4'b0010));
      check("drop frozen", data, dy);
    end
    tick();
    check("drop release grant", 64'(grant), 64'(0));
    check("drop release busy",  64'(busy),  64'(0));
    check("drop release owner", 64'(owner), 64'(1));
    check("drop lag data", data, dy);
    tick();
    check("drop blank", data, ALL_BLANK);
    clear_inputs();

    // Reset during HOLD, then search restarts from client 0
    do_reset(2);
    value[2] = 32'h0000_0042;
    req      = 4'b0100;
    tick();
    check("mid grant", 64'(grant), 64'(4'b0100));
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid rst grant", 64'(grant), 64'(0));
    check("mid rst busy",  64'(busy),  64'(0));
    check("mid rst owner", 64'(owner), 64'(0));
    check("mid rst data",  data,       ALL_BLANK);
    rst = 1'b0;
    req = 4'b0010;
    tick();
    check("post rst grant", 64'(grant), 64'(4'b0010));
    check("post rst owner", 64'(owner), 64'(1));
    clear_inputs();

    // Randomized run against the reference model
    do_reset(2);
    model_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) req = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        value[i] = $urandom;
        dp[i]    = 8'($urandom);
        blank[i] = 8'($urandom & $urandom & $urandom);
      end
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      check("rand grant", 64'(grant), (m_owner >= 0) ? 64'(4'b0001 << m_owner) : 64'(0));
      check("rand busy",  64'(busy),  64'(m_owner >= 0));
      check("rand owner", 64'(owner), 64'(m_shown));
      check("rand data",  data,       m_data);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
